// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - three-port arbiter in front of the single-word SDRAM controller
// Holds the winner's request for the whole transaction and swallows the controller's two-cycle done.
module sdram_arbiter #(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] p0_addr,
  input  logic [31:0] p0_data,
  input  logic        p0_we,
  input  logic        p0_start,
  output logic [31:0] p0_q,
  output logic        p0_done,
  output logic        p0_err,
  input  logic [23:0] p1_addr,
  input  logic [31:0] p1_data,
  input  logic        p1_we,
  input  logic        p1_start,
  output logic [31:0] p1_q,
  output logic        p1_done,
  output logic        p1_err,
  input  logic [23:0] p2_addr,
  input  logic [31:0] p2_data,
  input  logic        p2_we,
  input  logic        p2_start,
  output logic [31:0] p2_q,
  output logic        p2_done,
  output logic        p2_err,
  output logic [23:0] sdc_addr,
  output logic [31:0] sdc_data,
  output logic        sdc_we,
  output logic        sdc_start,
  input  logic [31:0] sdc_q,
  input  logic        sdc_done,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RELEASE = 2'd2} state_t;
  localparam logic [1:0] NO_GRANT = 2'd3;

  logic [23:0] req_addr [3];
  logic [31:0] req_data [3];
  logic [2:0]  req_we, req_start;

  assign req_addr  = '{p0_addr, p1_addr, p2_addr};
  assign req_data  = '{p0_data, p1_data, p2_data};
  assign req_we    = {p2_we, p1_we, p0_we};
  assign req_start = {p2_start, p1_start, p0_start};

  state_t      state_q, state_d;
  logic [1:0]  rr_last_q, rr_last_d, grant_q, grant_d, winner;
  logic [31:0] wdog_q, wdog_d;
  logic [23:0] sdc_addr_q, sdc_addr_d;
  logic [31:0] sdc_data_q, sdc_data_d;
  logic        sdc_we_q, sdc_we_d, sdc_start_q, sdc_start_d;
  logic [31:0] q_q [3];
  logic [31:0] q_d [3];
  logic [2:0]  done_q, done_d, err_q, err_d;

  // Later candidates are visited first so the earliest match in search order wins.
  function automatic logic [1:0] pick(input logic [2:0] req, input logic [1:0] last);
    int idx;
    pick = NO_GRANT;
    if (ROUND_ROBIN) begin
      for (int i = 3; i >= 1; i--) begin
        idx = (int'(last) + i) % 3;
        if (req[idx]) pick = 2'(idx);
      end
    end else begin
      for (int i = 2; i >= 0; i--) begin
        if (req[i]) pick = 2'(i);
      end
    end
  endfunction

  assign winner = pick(req_start, rr_last_q);

  always_comb begin
    state_d     = state_q;
    rr_last_d   = rr_last_q;
    grant_d     = grant_q;
    wdog_d      = wdog_q;
    sdc_addr_d  = sdc_addr_q;
    sdc_data_d  = sdc_data_q;
    sdc_we_d    = sdc_we_q;
    sdc_start_d = sdc_start_q;
    q_d         = q_q;
    done_d      = '0;
    err_d       = '0;
    case (state_q)
      S_IDLE: begin
        // A done seen here is spurious; granting now could pair our start with it.
        if (!sdc_done && req_start != 3'b000) begin
          for (int i = 0; i < 3; i++) begin
            if (winner == 2'(i)) begin
              sdc_addr_d = req_addr[i];
              sdc_data_d = req_data[i];
              sdc_we_d   = req_we[i];
            end
          end
          sdc_start_d = 1'b1;
          grant_d     = winner;
          rr_last_d   = winner;
          wdog_d      = '0;
          state_d     = S_BUSY;
        end
      end
      S_BUSY: begin
        if (sdc_done) begin
          for (int i = 0; i < 3; i++) begin
            if (grant_q == 2'(i)) begin
              q_d[i]    = sdc_q;
              done_d[i] = 1'b1;
            end
          end
          sdc_start_d = 1'b0;
          grant_d     = NO_GRANT;
          state_d     = S_RELEASE;
        end else begin
          wdog_d = wdog_q + 32'd1;
          if (TIMEOUT_CYCLES != 0 && wdog_d == TIMEOUT_CYCLES) begin
            for (int i = 0; i < 3; i++) begin
              if (grant_q == 2'(i)) begin
                q_d[i]    = 32'hDEADBEEF;
                done_d[i] = 1'b1;
                err_d[i]  = 1'b1;
              end
            end
            sdc_start_d = 1'b0;
            grant_d     = NO_GRANT;
            state_d     = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        sdc_start_d = 1'b0;
        grant_d     = NO_GRANT;
        if (!sdc_done) state_d = S_IDLE;
      end
      default: state_d = S_RELEASE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RELEASE;
      rr_last_q   <= 2'd2;
      grant_q     <= NO_GRANT;
      wdog_q      <= '0;
      sdc_addr_q  <= '0;
      sdc_data_q  <= '0;
      sdc_we_q    <= 1'b0;
      sdc_start_q <= 1'b0;
      q_q         <= '{default: '0};
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_last_q   <= rr_last_d;
      grant_q     <= grant_d;
      wdog_q      <= wdog_d;
      sdc_addr_q  <= sdc_addr_d;
      sdc_data_q  <= sdc_data_d;
      sdc_we_q    <= sdc_we_d;
      sdc_start_q <= sdc_start_d;
      q_q         <= q_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign sdc_addr  = sdc_addr_q;
  assign sdc_data  = sdc_data_q;
  assign sdc_we    = sdc_we_q;
  assign sdc_start = sdc_start_q;
  assign grant     = grant_q;
  assign p0_q      = q_q[0];
  assign p1_q      = q_q[1];
  assign p2_q      = q_q[2];
  assign p0_done   = done_q[0];
  assign p1_done   = done_q[1];
  assign p2_done   = done_q[2];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p2_err    = err_q[2];

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter
// Instance 0 is round-robin, instance 1 fixed priority; both share requester stimulus.
module tb_sdram_arbiter;

  localparam int LAT = 7;
  localparam int TO  = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [23:0] p_addr [3];
  logic [31:0] p_data [3];
  logic [2:0]  p_we, p_start;

  wire [31:0] q_o [2][3];
  wire [2:0]  done_o [2];
  wire [2:0]  err_o [2];
  wire [23:0] sdc_addr_o [2];
  wire [31:0] sdc_data_o [2];
  wire [1:0]  sdc_we_o, sdc_start_o;
  wire [1:0]  grant_o [2];

  logic [1:0]  mdone = '0;
  logic [31:0] mq [2] = '{default: '0};
  logic        spur = 1'b0;
  logic        ctl_hang = 1'b0;
  int          cst [2] = '{0, 0};
  int          cnt [2] = '{0, 0};
  int          rises [2] = '{0, 0};
  logic [1:0]  start_prev = '0;
  wire  [1:0]  sdc_done_i = mdone | {2{spur}};

  for (genvar g = 0; g < 2; g++) begin : g_dut
    sdram_arbiter #(.ROUND_ROBIN(g == 0), .TIMEOUT_CYCLES(TO)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .p0_addr(p_addr[0]), .p0_data(p_data[0]), .p0_we(p_we[0]), .p0_start(p_start[0]),
      .p0_q(q_o[g][0]), .p0_done(done_o[g][0]), .p0_err(err_o[g][0]),
      .p1_addr(p_addr[1]), .p1_data(p_data[1]), .p1_we(p_we[1]), .p1_start(p_start[1]),
      .p1_q(q_o[g][1]), .p1_done(done_o[g][1]), .p1_err(err_o[g][1]),
      .p2_addr(p_addr[2]), .p2_data(p_data[2]), .p2_we(p_we[2]), .p2_start(p_start[2]),
      .p2_q(q_o[g][2]), .p2_done(done_o[g][2]), .p2_err(err_o[g][2]),
      .sdc_addr(sdc_addr_o[g]), .sdc_data(sdc_data_o[g]), .sdc_we(sdc_we_o[g]),
      .sdc_start(sdc_start_o[g]), .sdc_q(mq[g]), .sdc_done(sdc_done_i[g]),
      .grant(grant_o[g])
    );
  end

  function automatic logic [31:0] ctl_data(input logic [23:0] a);
    return 32'hCAFEF00D ^ {8'h00, a ^ 24'h000123};
  endfunction

  // Controller model: done rises LAT+1 edges after it sees start, stays high two cycles.
  always @(posedge clk) begin
    for (int g = 0; g < 2; g++) begin
      start_prev[g] <= sdc_start_o[g];
      if (sdc_start_o[g] && !start_prev[g]) rises[g] <= rises[g] + 1;
      case (cst[g])
        0: if (sdc_start_o[g] && !ctl_hang) begin cst[g] <= 1; cnt[g] <= LAT; end
        1: if (cnt[g] == 0) begin
             mdone[g] <= 1'b1;
             mq[g]    <= ctl_data(sdc_addr_o[g]);
             cst[g]   <= 2;
           end else cnt[g] <= cnt[g] - 1;
        2: cst[g] <= 3;
        default: begin mdone[g] <= 1'b0; cst[g] <= 0; end
      endcase
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  port;
    logic [31:0] q;
    logic        err;
    logic        chk_q;
  } exp_t;

  exp_t       sb0 [$];
  exp_t       sb1 [$];
  logic [1:0] chk_en = 2'b01;
  logic [2:0] prev_done [2] = '{default: '0};

  task automatic push(input int g, input int port, input logic [31:0] q, input logic err, input logic cq);
    exp_t e;
    e.port  = 2'(port);
    e.q     = q;
    e.err   = err;
    e.chk_q = cq;
    if (g == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 3; i++) begin
        if (chk_en[g] && done_o[g][i]) begin
          chk("done_one_cycle", 64'(prev_done[g][i]), 64'(0));
          have = 1'b0;
          if (g == 0) begin
            have = sb0.size() > 0;
            if (have) e = sb0.pop_front();
          end else begin
            have = sb1.size() > 0;
            if (have) e = sb1.pop_front();
          end
          chk("sb_expected_done", 64'(have), 64'(1));
          if (have) begin
            chk("sb_port", 64'(i), 64'(e.port));
            chk("sb_err", 64'(err_o[g][i]), 64'(e.err));
            if (e.chk_q) chk("sb_q", 64'(q_o[g][i]), 64'(e.q));
          end
        end
        if (chk_en[g] && err_o[g][i]) chk("err_with_done", 64'(done_o[g][i]), 64'(1));
      end
      prev_done[g] <= done_o[g];
    end
  end

  int cyc, n_hi, bad, n, r0;

  // Drives one request on instance 0's view and scrambles the inputs once granted.
  task automatic txn(input int port, input logic [23:0] a, input logic [31:0] d, input logic we,
                     output int c, output int hi, output int b);
    p_addr[port] = a;
    p_data[port] = d;
    p_we[port] = we;
    p_start[port] = 1'b1;
    c = 0; hi = 0; b = 0;
    while (c < 200) begin
      @(negedge clk);
      c++;
      if (sdc_start_o[0]) begin
        hi++;
        if ({sdc_addr_o[0], sdc_data_o[0], sdc_we_o[0]} != {a, d, we}) b++;
        p_addr[port] = ~a;
        p_data[port] = ~d;
      end
      if (done_o[0][port]) break;
    end
    chk("txn_done_seen", 64'(done_o[0][port]), 64'(1));
    p_start[port] = 1'b0;
    p_we[port] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    p_addr = '{default: '0};
    p_data = '{default: '0};
    p_we = '0;
    p_start = '0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 64'(grant_o[0]), 64'(3));
    chk("rst_sdc_start", 64'(sdc_start_o[0]), 64'(0));
    chk("rst_done", 64'(done_o[0]), 64'(0));
    chk("rst_err", 64'(err_o[0]), 64'(0));
    chk("rst_q1", 64'(q_o[0][1]), 64'(0));
    chk("rst_sdc_addr", 64'(sdc_addr_o[0]), 64'(0));
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    push(0, 1, 32'hCAFEF00D, 1'b0, 1'b1);
    txn(1, 24'h000123, 32'h0, 1'b0, cyc, n_hi, bad);
    chk("rd_done_latency", 64'(cyc), 64'(LAT + 4));
    chk("rd_start_cycles", 64'(n_hi), 64'(LAT + 3));
    chk("rd_start_low_at_done", 64'(sdc_start_o[0]), 64'(0));
    chk("rd_sdc_stable", 64'(bad), 64'(0));

    repeat (2) @(negedge clk);
    r0 = rises[0];
    push(0, 2, 32'h0, 1'b0, 1'b0);
    txn(2, 24'h000456, 32'h12345678, 1'b1, cyc, n_hi, bad);
    chk("wr_sdc_stable", 64'(bad), 64'(0));
    chk("wr_start_cycles", 64'(n_hi), 64'(LAT + 3));
    repeat (12) @(negedge clk);
    chk("wr_single_txn", 64'(rises[0] - r0), 64'(1));

    chk_en = 2'b11;
    p_addr[0] = 24'h000010; p_addr[1] = 24'h000020; p_addr[2] = 24'h000030;
    p_we = '0;
    for (int k = 0; k < 6; k++) begin
      push(0, k % 3, ctl_data(p_addr[k % 3]), 1'b0, 1'b1);
      push(1, 0, ctl_data(p_addr[0]), 1'b0, 1'b1);
    end
    p_start = 3'b111;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (|done_o[0]) n++;
    end
    p_start[0] = 1'b0;
    push(0, 1, ctl_data(p_addr[1]), 1'b0, 1'b1);
    push(1, 1, ctl_data(p_addr[1]), 1'b0, 1'b1);
    while (n < 7 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (|done_o[0]) n++;
    end
    p_start = '0;
    chk("cont_done_count", 64'(n), 64'(7));
    repeat (15) @(negedge clk);
    chk("cont_fp_sb_drained", 64'(sb1.size()), 64'(0));
    chk_en = 2'b01;

    ctl_hang = 1'b1;
    push(0, 0, 32'hDEADBEEF, 1'b1, 1'b1);
    txn(0, 24'h000777, 32'h0, 1'b0, cyc, n_hi, bad);
    chk("to_start_cycles", 64'(n_hi), 64'(TO));
    chk("to_addr_stable", 64'(bad), 64'(0));
    ctl_hang = 1'b0;

    repeat (3) @(negedge clk);
    spur = 1'b1;
    p_addr[2] = 24'h000ABC;
    p_we[2] = 1'b0;
    p_start[2] = 1'b1;
    push(0, 2, ctl_data(24'h000ABC), 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("spur_no_grant", 64'(grant_o[0]), 64'(3));
    chk("spur_no_start", 64'(sdc_start_o[0]), 64'(0));
    spur = 1'b0;
    txn(2, 24'h000ABC, 32'h0, 1'b0, cyc, n_hi, bad);
    chk("post_spur_stable", 64'(bad), 64'(0));

    repeat (3) @(negedge clk);
    p_addr[0] = 24'h000050; p_addr[1] = 24'h000060;
    p_start = 3'b011;
    cyc = 0;
    while (!sdc_done_i[0] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstm_busy_reached", 64'(sdc_done_i[0]), 64'(1));
    reset_n = 1'b0;
    #1;
    chk("rstm_grant", 64'(grant_o[0]), 64'(3));
    chk("rstm_sdc_start", 64'(sdc_start_o[0]), 64'(0));
    chk("rstm_q0_clear", 64'(q_o[0][0]), 64'(0));
    p_start[0] = 1'b0;
    push(0, 1, ctl_data(24'h000060), 1'b0, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rstm_hold_done_high", 64'(grant_o[0]), 64'(3));
    @(negedge clk);
    chk("rstm_hold_release", 64'(grant_o[0]), 64'(3));
    @(negedge clk);
    chk("rstm_grant_p1", 64'(grant_o[0]), 64'(1));
    chk("rstm_start_p1", 64'(sdc_start_o[0]), 64'(1));
    cyc = 0;
    while (!done_o[0][1] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("rstm_p1_done", 64'(done_o[0][1]), 64'(1));
    p_start = '0;
    repeat (5) @(negedge clk);
    chk("sb0_drained", 64'(sb0.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
